trdb_branch_map_unpacker: RTL and testbench

// Decoder-side counterpart of the encoder's branch detection/taken logic.

---
 rtl/trdb_pkg.sv | 16 +
 rtl/trdb_branch_map_unpacker.sv | 106 ++++++++++
 tb/tb_trdb_branch_map_unpacker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants and types for the branch-map encoder/decoder pair.
// The map bit polarity lives here so both sides can never disagree on it.
package trdb_pkg;

  localparam int BMAP_LEN = 31;
  localparam int CNT_W    = $clog2(BMAP_LEN + 1);

  // A set map bit means the branch was NOT taken.
  localparam logic BMAP_NOT_TAKEN = 1'b1;

  typedef enum logic {
    IDLE,
    DRAIN
  } unpk_state_e;

endpackage

// File: rtl/trdb_branch_map_unpacker.sv
// Replays one branch-map payload as a stream of taken/not-taken outcomes, oldest first.
// Payload accept is allowed during the final outcome handshake so maps can run back-to-back.
module trdb_branch_map_unpacker #(
  parameter int  BMAP_LEN = trdb_pkg::BMAP_LEN,
  localparam int CNT_W    = $clog2(BMAP_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                pkt_valid_i,
  output logic                pkt_ready_o,
  input  logic [4:0]          branches_i,
  input  logic [BMAP_LEN-1:0] branch_map_i,
  output logic                br_valid_o,
  input  logic                br_ready_i,
  output logic                taken_o,
  output logic                last_o,
  output logic [CNT_W-1:0]    remaining_o
);

  import trdb_pkg::*;

  unpk_state_e         state_q, state_d;
  logic [BMAP_LEN-1:0] map_q, map_d;
  logic [BMAP_LEN-1:0] load_mask;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    load_cnt;
  logic                is_last;
  logic                accept;
  logic                pop;

  // A zero count means a full map; anything beyond the map width is clamped to it.
  always_comb begin
    load_cnt = CNT_W'(BMAP_LEN);
    if ((branches_i != 5'd0) && (int'(branches_i) <= BMAP_LEN)) begin
      load_cnt = CNT_W'(branches_i);
    end
    load_mask = '0;
    for (int i = 0; i < BMAP_LEN; i++) begin
      load_mask[i] = (i < int'(load_cnt));
    end
  end

  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    cnt_d       = cnt_q;
    pkt_ready_o = 1'b0;
    br_valid_o  = 1'b0;
    accept      = 1'b0;
    pop         = 1'b0;
    is_last     = (cnt_q == CNT_W'(1));

    if (flush_i) begin
      state_d = IDLE;
      map_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pkt_ready_o = 1'b1;
        end
        DRAIN: begin
          br_valid_o  = 1'b1;
          pop         = br_ready_i;
          pkt_ready_o = is_last && br_ready_i;
          if (pop) begin
            map_d = map_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (is_last) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Bits above the count are dropped at load so they can never reach taken_o.
      accept = pkt_valid_i && pkt_ready_o;
      if (accept) begin
        map_d   = branch_map_i & load_mask;
        cnt_d   = load_cnt;
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      map_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
    end
  end

  assign taken_o     = br_valid_o && (map_q[0] != BMAP_NOT_TAKEN);
  assign last_o      = br_valid_o && is_last;
  assign remaining_o = cnt_q;

endmodule

// File: tb/tb_trdb_branch_map_unpacker.sv
// Directed and random stimulus for the branch-map unpacker, checked against a
// queue of pending outcomes built directly from the payload count/map rules.
module tb_trdb_branch_map_unpacker;

  localparam int LEN = 31;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [4:0]  branches_i;
  logic [30:0] branch_map_i;
  logic        br_valid_o;
  logic        br_ready_i;
  logic        taken_o;
  logic        last_o;
  logic [4:0]  remaining_o;

  int errors = 0;
  int checks = 0;

  bit expQ[$];
  bit obsTaken[$];
  int obsRem[$];

  trdb_branch_map_unpacker dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_ready_o  (pkt_ready_o),
    .branches_i   (branches_i),
    .branch_map_i (branch_map_i),
    .br_valid_o   (br_valid_o),
    .br_ready_i   (br_ready_i),
    .taken_o      (taken_o),
    .last_o       (last_o),
    .remaining_o  (remaining_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expand a payload into its pending outcomes: count 0 or >LEN means LEN, map bit 1 = not taken.
  task automatic pushMap(input logic [4:0] br, input logic [30:0] map);
    int n;
    n = (br == 5'd0 || int'(br) > LEN) ? LEN : int'(br);
    for (int i = 0; i < n; i++) expQ.push_back(map[i] == 1'b0);
  endtask

  task automatic checkOutput(input logic rdy, input logic fl, output bit expPop, output bit expAcc,
                             input logic pv);
    bit  v;
    bit  r;
    int  sz;
    sz = expQ.size();
    v  = !fl && (sz > 0);
    r  = !fl && ((sz == 0) || (sz == 1 && rdy));
    check("br_valid", br_valid_o, v);
    check("pkt_ready", pkt_ready_o, r);
    check("taken", taken_o, v ? expQ[0] : 1'b0);
    check("last", last_o, v && (sz == 1));
    check("remaining", remaining_o, sz);
    expPop = v && rdy;
    expAcc = r && pv;
  endtask

  // Drive one cycle (entered just after a rising edge), check mid-cycle, advance the model.
  task automatic applyStimulus(input logic pv, input logic [4:0] br, input logic [30:0] map,
                               input logic rdy, input logic fl);
    bit p;
    bit a;
    pkt_valid_i  = pv;
    branches_i   = br;
    branch_map_i = map;
    br_ready_i   = rdy;
    flush_i      = fl;
    @(negedge clk_i);
    checkOutput(rdy, fl, p, a, pv);
    if (br_valid_o && rdy && !fl) begin
      obsTaken.push_back(taken_o);
      obsRem.push_back(int'(remaining_o));
    end
    @(posedge clk_i);
    #1;
    if (fl) expQ.delete();
    else begin
      if (p) void'(expQ.pop_front());
      if (a) pushMap(br, map);
    end
  endtask

  task automatic clearLogs();
    obsTaken.delete();
    obsRem.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_pkt_ready"}, pkt_ready_o, 1'b1);
    check({tag, "_br_valid"}, br_valid_o, 1'b0);
    check({tag, "_taken"}, taken_o, 1'b0);
    check({tag, "_last"}, last_o, 1'b0);
    check({tag, "_remaining"}, remaining_o, 0);
  endtask

  initial begin
    logic [30:0] rmap;
    logic [4:0]  rbr;

    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    pkt_valid_i  = 1'b0;
    branches_i   = '0;
    branch_map_i = '0;
    br_ready_i   = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] three-branch map");
    clearLogs();
    applyStimulus(1'b1, 5'd3, 31'b010, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("t1_beats", obsTaken.size(), 3);
    if (obsTaken.size() == 3) begin
      check("t1_taken0", obsTaken[0], 1'b1);
      check("t1_taken1", obsTaken[1], 1'b0);
      check("t1_taken2", obsTaken[2], 1'b1);
      check("t1_rem0", obsRem[0], 3);
      check("t1_rem2", obsRem[2], 1);
    end

    $display("[TB] full map");
    clearLogs();
    applyStimulus(1'b1, 5'd0, 31'd0, 1'b1, 1'b0);
    repeat (32) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("t2_beats", obsTaken.size(), 31);

    $display("[TB] backpressure");
    clearLogs();
    applyStimulus(1'b1, 5'd2, 31'b01, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 5'd0, 31'd0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("t3_beats", obsTaken.size(), 2);
    if (obsTaken.size() == 2) begin
      check("t3_taken0", obsTaken[0], 1'b0);
      check("t3_taken1", obsTaken[1], 1'b1);
    end

    $display("[TB] back-to-back");
    clearLogs();
    applyStimulus(1'b1, 5'd2, 31'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd1, 31'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("t4_beats", obsTaken.size(), 3);
    if (obsRem.size() == 3) check("t4_rem2", obsRem[2], 1);

    $display("[TB] garbage high bits");
    clearLogs();
    applyStimulus(1'b1, 5'd2, 31'h7FFF_FFFC, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("t5_beats", obsTaken.size(), 2);
    if (obsTaken.size() == 2) begin
      check("t5_taken0", obsTaken[0], 1'b1);
      check("t5_taken1", obsTaken[1], 1'b1);
    end

    $display("[TB] flush mid-map");
    applyStimulus(1'b1, 5'd4, 31'b1010, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd3, 31'd0, 1'b1, 1'b1);
    check("t6_idle_remaining", remaining_o, 0);
    applyStimulus(1'b1, 5'd1, 31'd1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);

    $display("[TB] reset mid-map");
    applyStimulus(1'b1, 5'd5, 31'b10110, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 31'd0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkResetOutputs("midreset");
    expQ.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (3) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      rbr  = 5'($urandom);
      rmap = 31'($urandom);
      applyStimulus(($urandom % 3) == 0, rbr, rmap, ($urandom % 10) < 7, ($urandom % 50) == 0);
    end
    repeat (40) applyStimulus(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    check("final_idle", remaining_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
